lab3_mem_line_to_word_adapter: RTL and testbench
================================================

Name: lab3_mem_line_to_word_adapter

Overview:
- Sits directly downstream of the blocking cache's memory-request/memory-response port.
- Serializes each 128-bit cache-line memory transaction (refill read or eviction write) into four sequential 32-bit word transactions to a word-wide main memory.
- For reads, reassembles the four returned words into one 128-bit line response to the cache; for writes, acknowledges the line once all four word writes complete.
- Blocking: one line in flight, one word outstanding at a time.

Parameters:
p_opaque_nbits, 8, width of the opaque field carried from line request to line response
p_addr_nbits, 32, address width (line and word)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clk)
memreq_val  input  1  line request valid (from cache)
memreq_rdy  output  1  line request ready
memreq_type  input  3  0=read, 1=write
memreq_opaque  input  p_opaque_nbits  tag returned in response
memreq_addr  input  p_addr_nbits  line address; bits [3:0] ignored
memreq_data  input  128  write line data
memresp_val  output  1  line response valid (to cache)
memresp_rdy  input  1  line response ready
memresp_type  output  3  echo of latched memreq_type
memresp_opaque  output  p_opaque_nbits  echo of latched opaque
memresp_data  output  128  assembled read line; 0 for writes
wmemreq_val  output  1  word request valid (to memory)
wmemreq_rdy  input  1  word request ready
wmemreq_type  output  3  0=read, 1=write
wmemreq_addr  output  p_addr_nbits  word address
wmemreq_data  output  32  write word
wmemresp_val  input  1  word response valid
wmemresp_rdy  output  1  word response ready
wmemresp_data  input  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP (2-bit encoding). A 2-bit word counter cnt holds the current word index.
- Latched on line accept: type, opaque, line address [p_addr_nbits-1:4], write data.
- Line buffer: 128 bits.
- Reset (reset==0 at posedge): state=IDLE, cnt=0, buffer=0, latched fields=0.
- Output values:
  - memreq_rdy=1 only in IDLE.
  - memresp_val=1 only in RESP.
  - wmemreq_val=1 only in REQ.
  - wmemresp_rdy=1 only in WAIT.
  - With reset asserted, all val/rdy outputs are 0 that cycle; afterwards they follow state.
- IDLE: on memreq_val&&memreq_rdy, latch request fields, set cnt=0, clear the buffer, and go to REQ.
- REQ:
  - wmemreq_addr = {line_addr, cnt, 2'b00}.
  - wmemreq_type = 1 if the latched type==1, else 0.
  - wmemreq_data = latched data[32*cnt+31 : 32*cnt].
  - On wmemreq_val&&wmemreq_rdy go to WAIT; otherwise hold with all outputs stable.
- WAIT: on wmemresp_val&&wmemresp_rdy:
  - Read: write wmemresp_data into buffer[32*cnt+31 : 32*cnt].
  - Write: response data is ignored.
  - If cnt==3, go to RESP; else cnt=cnt+1 and go to REQ.
- RESP:
  - Outputs: memresp_type = latched type; memresp_opaque = latched opaque.
  - memresp_data = buffer for reads, 128'h0 for writes.
  - On memresp_val&&memresp_rdy go to IDLE; otherwise hold with outputs stable.
- Type handling: any type other than 1 is executed as a read; memresp_type still echoes the original value.
- Latency: with memory ready and zero-latency responses, the line response is valid 9 cycles after the accept cycle (1 to REQ + 4×(REQ+WAIT) − 1 + RESP entry); the next line can be accepted the cycle after the response fires.
- Word order: always ascending, 0→3.
- Counter wrap: cnt wraps 3→0 only on the IDLE accept; no fifth word is ever issued.
- Inputs outside the matching state are ignored and never captured: wmemresp_val outside WAIT, memreq_val outside IDLE.
- Reset mid-operation: abort immediately to IDLE, discard partial line, no response issued. A word response still pending in memory must be drained by the environment before the next request.
- memreq_addr[3:0] are ignored and never appear on wmemreq_addr.

Test Plan:
- Refill read: memreq type=0, addr=0x00001234, opaque=0x5A; memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  -> word addrs 0x1230, 0x1234, 0x1238, 0x123C; memresp_data=0x44444444_33333333_22222222_11111111, type=0, opaque=0x5A, 9 cycles after accept.
- Eviction write: type=1, addr=0x00000100, data=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
  -> wmemreq writes 0xAAAAAAAA@0x100, 0xBBBBBBBB@0x104, 0xCCCCCCCC@0x108, 0xDDDDDDDD@0x10C; memresp type=1, data=0.
- Backpressure: wmemreq_rdy=0 for 3 cycles on word 2, and memresp_rdy=0 for 2 cycles in RESP.
  -> outputs held stable, no duplicate word request, single line response.
- Back-to-back: eviction write to 0x200 immediately followed by refill read of 0x300.
  -> second memreq accepted the cycle after the first memresp fires; read addresses start at 0x300 with cnt restarted at 0.
- Reset mid-line: reset=0 during WAIT of word 1 of a read.
  -> next cycle IDLE, memreq_rdy=1, memresp_val=0, buffer=0; a subsequent read returns only new data.
- Spurious response: wmemresp_val=1 with data 0xFFFFFFFF while in IDLE and REQ.
  -> wmemresp_rdy=0, buffer unchanged, final line excludes 0xFFFFFFFF.

Source files
------------

// File: rtl/lab3_mem_line_to_word_adapter.sv
// Adapts 128-bit cache-line memory transactions into four sequential 32-bit word
// transactions. Refill reads are reassembled into a line; eviction writes are acked per line.
module lab3_mem_line_to_word_adapter #(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      memreq_val,
  output logic                      memreq_rdy,
  input  logic [2:0]                memreq_type,
  input  logic [p_opaque_nbits-1:0] memreq_opaque,
  input  logic [p_addr_nbits-1:0]   memreq_addr,
  input  logic [127:0]              memreq_data,

  output logic                      memresp_val,
  input  logic                      memresp_rdy,
  output logic [2:0]                memresp_type,
  output logic [p_opaque_nbits-1:0] memresp_opaque,
  output logic [127:0]              memresp_data,

  output logic                      wmemreq_val,
  input  logic                      wmemreq_rdy,
  output logic [2:0]                wmemreq_type,
  output logic [p_addr_nbits-1:0]   wmemreq_addr,
  output logic [31:0]               wmemreq_data,

  input  logic                      wmemresp_val,
  output logic                      wmemresp_rdy,
  input  logic [31:0]               wmemresp_data
);

  localparam int unsigned LINE_W  = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned LADDR_W = p_addr_nbits - 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                    state;
  logic [1:0]                cnt;
  logic [LINE_W-1:0]         buffer;
  logic [LINE_W-1:0]         wdata;
  logic [TYPE_W-1:0]         type_q;
  logic [p_opaque_nbits-1:0] opaque_q;
  logic [LADDR_W-1:0]        line_addr;
  logic                      is_write;
  logic                      unused_addr_bits;

  // Byte offset within the line never reaches the word port.
  assign unused_addr_bits = ^memreq_addr[3:0];

  // Only type 1 is a write; every other encoding is executed as a read.
  assign is_write = (type_q == 3'd1);

  // Handshake strobes decode the state and are forced low while reset is held.
  assign memreq_rdy   = reset && (state == IDLE);
  assign wmemreq_val  = reset && (state == REQ);
  assign wmemresp_rdy = reset && (state == WAIT);
  assign memresp_val  = reset && (state == RESP);

  assign wmemreq_type   = TYPE_W'(is_write);
  assign wmemreq_addr   = {line_addr, cnt, 2'b00};
  assign wmemreq_data   = wdata[{cnt, 5'd0} +: WORD_W];
  assign memresp_type   = type_q;
  assign memresp_opaque = opaque_q;
  assign memresp_data   = is_write ? '0 : buffer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      buffer    <= '0;
      wdata     <= '0;
      type_q    <= '0;
      opaque_q  <= '0;
      line_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memreq_val && memreq_rdy) begin
            type_q    <= memreq_type;
            opaque_q  <= memreq_opaque;
            line_addr <= memreq_addr[p_addr_nbits-1:4];
            wdata     <= memreq_data;
            cnt       <= 2'd0;
            buffer    <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (wmemreq_val && wmemreq_rdy) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wmemresp_val && wmemresp_rdy) begin
            if (!is_write) begin
              buffer[{cnt, 5'd0} +: WORD_W] <= wmemresp_data;
            end
            // Last word closes the line; the counter only restarts on the next accept.
            if (cnt == 2'd3) begin
              state <= RESP;
            end else begin
              cnt   <= cnt + 2'd1;
              state <= REQ;
            end
          end
        end
        RESP: begin
          if (memresp_val && memresp_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_mem_line_to_word_adapter.sv
// Bench for the line-to-word adapter: a word memory model (associative array) answers
// word requests while each line transaction is checked against the memory contents.
module tb_lab3_mem_line_to_word_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic         memreq_val;
  logic         memreq_rdy;
  logic [2:0]   memreq_type;
  logic [7:0]   memreq_opaque;
  logic [31:0]  memreq_addr;
  logic [127:0] memreq_data;
  logic         memresp_val;
  logic         memresp_rdy;
  logic [2:0]   memresp_type;
  logic [7:0]   memresp_opaque;
  logic [127:0] memresp_data;
  logic         wmemreq_val;
  logic         wmemreq_rdy;
  logic [2:0]   wmemreq_type;
  logic [31:0]  wmemreq_addr;
  logic [31:0]  wmemreq_data;
  logic         wmemresp_val;
  logic         wmemresp_rdy;
  logic [31:0]  wmemresp_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [logic [31:0]];

  lab3_mem_line_to_word_adapter #(
    .p_opaque_nbits(8),
    .p_addr_nbits  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memreq_type   (memreq_type),
    .memreq_opaque (memreq_opaque),
    .memreq_addr   (memreq_addr),
    .memreq_data   (memreq_data),
    .memresp_val   (memresp_val),
    .memresp_rdy   (memresp_rdy),
    .memresp_type  (memresp_type),
    .memresp_opaque(memresp_opaque),
    .memresp_data  (memresp_data),
    .wmemreq_val   (wmemreq_val),
    .wmemreq_rdy   (wmemreq_rdy),
    .wmemreq_type  (wmemreq_type),
    .wmemreq_addr  (wmemreq_addr),
    .wmemreq_data  (wmemreq_data),
    .wmemresp_val  (wmemresp_val),
    .wmemresp_rdy  (wmemresp_rdy),
    .wmemresp_data (wmemresp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // One full line transaction; starts and ends at a negedge.
  task automatic line_txn(input logic [2:0] typ, input logic [31:0] addr, input logic [7:0] op,
                          input logic [127:0] wd, input int stall_word, input int stall_cyc,
                          input int resp_stall, input bit spurious, input string tag);
    logic [31:0]  base, exp_a, exp_d;
    logic [127:0] exp_line;
    int issued, answered, cyc, acc_cyc, s_left, r_left;
    bit pend, done, accepted, seen;
    base = {addr[31:4], 4'h0};
    exp_line = '0;
    if (typ != 3'd1)
      for (int i = 0; i < 4; i++) exp_line[32*i +: 32] = mem_rd(base + 32'(4*i));
    issued = 0; answered = 0; cyc = 0; acc_cyc = -100;
    s_left = stall_cyc; r_left = resp_stall;
    pend = 0; done = 0; accepted = 0; seen = 0;

    n_vec++;
    if (memreq_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL %s start_rdy: memreq_rdy=%b want 1", tag, memreq_rdy);
    end
    memreq_val = 1'b1; memreq_type = typ; memreq_opaque = op;
    memreq_addr = addr; memreq_data = wd;

    while (!done && cyc < 300) begin
      if (accepted) memreq_val = 1'b0;
      else if (memreq_rdy === 1'b1) begin accepted = 1; acc_cyc = cyc; end

      wmemreq_rdy = 1'b0;
      if (wmemreq_val === 1'b1) begin
        exp_a = base + 32'(4*issued);
        exp_d = wd[32*(issued & 3) +: 32];
        n_vec++;
        if (issued > 3 || wmemreq_addr !== exp_a || wmemreq_type !== 3'(typ == 3'd1) ||
            (typ == 3'd1 && wmemreq_data !== exp_d)) begin
          n_err++;
          $display("FAIL %s word_req%0d: addr=%h type=%0d data=%h want addr=%h type=%0d data=%h",
                   tag, issued, wmemreq_addr, wmemreq_type, wmemreq_data, exp_a,
                   (typ == 3'd1), exp_d);
        end
        if (issued == stall_word && s_left > 0) s_left--;
        else begin
          wmemreq_rdy = 1'b1;
          if (typ == 3'd1) mem[exp_a] = exp_d;
          pend = 1; issued++;
        end
      end

      wmemresp_val = 1'b0; wmemresp_data = '0;
      if (wmemresp_rdy === 1'b1) begin
        n_vec++;
        if (!pend) begin
          n_err++;
          $display("FAIL %s word_resp: wmemresp_rdy=1 with no word outstanding, want 0", tag);
        end
        wmemresp_val = 1'b1;
        wmemresp_data = (typ == 3'd1) ? $urandom : mem_rd(base + 32'(4*answered));
        pend = 0; answered++;
      end else if (spurious) begin
        wmemresp_val = 1'b1; wmemresp_data = 32'hFFFF_FFFF;
      end

      memresp_rdy = 1'b0;
      if (memresp_val === 1'b1) begin
        n_vec++;
        if (!seen && stall_cyc == 0 && resp_stall == 0 && cyc != acc_cyc + 9) begin
          n_err++;
          $display("FAIL %s latency: resp after %0d cycles want 9", tag, cyc - acc_cyc);
        end
        seen = 1;
        n_vec++;
        if (memresp_type !== typ || memresp_opaque !== op || memresp_data !== exp_line) begin
          n_err++;
          $display("FAIL %s line_resp: type=%0d op=%h data=%h want type=%0d op=%h data=%h",
                   tag, memresp_type, memresp_opaque, memresp_data, typ, op, exp_line);
        end
        if (r_left > 0) r_left--;
        else begin memresp_rdy = 1'b1; done = 1; end
      end

      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    memreq_val = 1'b0; wmemreq_rdy = 1'b0; wmemresp_val = 1'b0; memresp_rdy = 1'b0;
    n_vec++;
    if (!done || issued != 4 || answered != 4 || memresp_val !== 1'b0) begin
      n_err++;
      $display("FAIL %s completion: done=%0d words=%0d/%0d resp_val_after=%b want 1 4/4 0",
               tag, done, issued, answered, memresp_val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    memreq_val = 1'b0; memreq_type = '0; memreq_opaque = '0; memreq_addr = '0; memreq_data = '0;
    memresp_rdy = 1'b0; wmemreq_rdy = 1'b0; wmemresp_val = 1'b0; wmemresp_data = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: rdy/val=%b want 0000",
               {memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy});
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_release: rdy/val=%b want 1000",
               {memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy});
    end
  endtask

  task automatic test_refill_read();
    mem[32'h1230] = 32'h1111_1111; mem[32'h1234] = 32'h2222_2222;
    mem[32'h1238] = 32'h3333_3333; mem[32'h123C] = 32'h4444_4444;
    line_txn(3'd0, 32'h0000_1234, 8'h5A, '0, -1, 0, 0, 1'b0, "refill_read");
  endtask

  task automatic test_eviction_write();
    line_txn(3'd1, 32'h0000_0100, 8'h21,
             128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, -1, 0, 0, 1'b0, "eviction_write");
    n_vec++;
    if (mem[32'h108] !== 32'hCCCC_CCCC) begin
      n_err++;
      $display("FAIL eviction_mem: mem[0x108]=%h want cccccccc", mem[32'h108]);
    end
  endtask

  task automatic test_backpressure();
    line_txn(3'd0, 32'h0000_0A40, 8'h33, '0, 2, 3, 2, 1'b0, "backpressure_read");
    line_txn(3'd1, 32'h0000_0A80, 8'h34, {$urandom, $urandom, $urandom, $urandom},
             2, 3, 2, 1'b0, "backpressure_write");
  endtask

  task automatic test_back_to_back();
    line_txn(3'd1, 32'h0000_0200, 8'h01, {$urandom, $urandom, $urandom, $urandom},
             -1, 0, 0, 1'b0, "b2b_write");
    line_txn(3'd0, 32'h0000_0300, 8'h02, '0, -1, 0, 0, 1'b0, "b2b_read");
  endtask

  task automatic test_reset_mid_line();
    int words, cyc;
    bit hit;
    words = 0; hit = 0;
    memreq_val = 1'b1; memreq_type = 3'd0; memreq_opaque = 8'h77;
    memreq_addr = 32'h0000_0400; memreq_data = '0;
    for (cyc = 0; cyc < 50 && !hit; cyc++) begin
      if (memreq_rdy !== 1'b1) memreq_val = 1'b0;
      wmemreq_rdy = (wmemreq_val === 1'b1);
      wmemresp_val = 1'b0;
      if (wmemresp_rdy === 1'b1) begin
        if (words == 1) hit = 1;
        else begin
          wmemresp_val = 1'b1; wmemresp_data = mem_rd(32'h400 + 32'(4*words)); words++;
        end
      end
      if (!hit) begin @(posedge clk); @(negedge clk); end
    end
    memreq_val = 1'b0; wmemreq_rdy = 1'b0; wmemresp_val = 1'b0;
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid_reach: word1 wait reached=%0d want 1", hit);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_assert: rdy/val=%b want 0000",
               {memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_mid_idle: rdy/val=%b want 1000",
               {memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy});
    end
    line_txn(3'd0, 32'h0000_0500, 8'h78, '0, -1, 0, 0, 1'b0, "reset_mid_next_read");
  endtask

  task automatic test_spurious();
    line_txn(3'd0, 32'h0000_0600, 8'h99, '0, -1, 0, 0, 1'b1, "spurious_read");
    line_txn(3'd0, 32'h0000_0640, 8'h9A, '0, 1, 2, 1, 1'b1, "spurious_stall_read");
  endtask

  task automatic test_random();
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [127:0] wd;
    for (int i = 0; i < 24; i++) begin
      typ  = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
      addr = 32'h0000_8000 | ($urandom & 32'h0000_03FF);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      line_txn(typ, addr, 8'($urandom), wd, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_refill_read();
    test_eviction_write();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_line();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
